// File: rtl/fork_dispatcher.sv
// fork_dispatcher
//
// Holds FORK messages from an upstream node in a small FIFO and releases them
// one at a time to the downstream node, only while that node reports idle.
// SUBSTITUTION_MASK messages skip the FIFO and reach the outputs one cycle
// after they arrive. A bypass in the same cycle as a possible dispatch wins,
// and the fork waits in the FIFO.
//
// Handshake: the upstream side has no backpressure. A FORK is offered when
// in_valid=1 and in_msg_type=01, and it is taken in that cycle. If the FIFO is
// full and nothing leaves in that cycle, the fork is dropped and the sticky
// overflow flag is set. The downstream side is paced by dn_busy, not by a
// ready signal. Each dispatch is a one-cycle pulse with out_valid=1.
//
// Ports:
//   clk, rst       : clock and asynchronous active-high reset
//   in_var         : upstream outgoing_var
//   in_valid       : upstream outgoing_var_valid
//   in_msg_type    : 00 NONE, 01 FORK, 10 SUBSTITUTION_MASK, 11 reserved
//   in_mask        : upstream outgoing_mask
//   dn_busy        : downstream node_busy
//   out_var        : downstream incoming_var (registered)
//   out_valid      : downstream incoming_var_valid (registered)
//   out_msg_type   : downstream incoming_msg_type (registered)
//   out_mask       : downstream incoming_mask (registered)
//   fifo_count     : FIFO occupancy, 0..DEPTH
//   overflow       : sticky, set when a fork is dropped
//   dbg_state      : dispatch FSM state (0 READY, 1 ARMED, 2 WAIT)
module fork_dispatcher #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_var,
  input  logic          in_valid,
  input  logic [1:0]    in_msg_type,
  input  logic [2:0]    in_mask,
  input  logic          dn_busy,
  output logic [7:0]    out_var,
  output logic          out_valid,
  output logic [1:0]    out_msg_type,
  output logic [2:0]    out_mask,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  output logic [1:0]    dbg_state
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] MSG_NONE = 2'b00;
  localparam logic [1:0] MSG_FORK = 2'b01;
  localparam logic [1:0] MSG_SUB  = 2'b10;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_ARMED = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            overflow_q;
  logic [7:0]      out_var_q;
  logic            out_valid_q;
  logic [1:0]      out_msg_type_q;
  logic [2:0]      out_mask_q;

  logic            is_fork;
  logic            is_bypass;
  logic            fifo_full;
  logic            dispatch;
  logic            push_ok;
  logic            drop;

  always_comb begin
    is_fork   = in_valid && (in_msg_type == MSG_FORK);
    // in_valid does not gate a bypass; it is forwarded as out_valid.
    is_bypass = (in_msg_type == MSG_SUB);
    fifo_full = (count_q == CW'(DEPTH));
    // Only entries present at the start of the cycle may leave. A fork
    // pushed this cycle becomes eligible next cycle.
    dispatch  = (state_q == ST_READY) && (count_q != '0) && !dn_busy && !is_bypass;
    // When full, a simultaneous pop frees the slot the push needs.
    push_ok   = is_fork && (!fifo_full || dispatch);
    drop      = is_fork && fifo_full && !dispatch;

    count_d = count_q;
    if (push_ok && !dispatch) begin
      count_d = count_q + CW'(1);
    end else if (dispatch && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage has no reset. Entries are only read below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= in_var;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_READY;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      out_var_q      <= 8'h00;
      out_valid_q    <= 1'b0;
      out_msg_type_q <= MSG_NONE;
      out_mask_q     <= 3'b000;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (dispatch) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end

      // Output register. Var and mask hold when nothing is sent.
      if (is_bypass) begin
        out_msg_type_q <= MSG_SUB;
        out_valid_q    <= in_valid;
        out_var_q      <= in_var;
        out_mask_q     <= in_mask;
      end else if (dispatch) begin
        out_msg_type_q <= MSG_FORK;
        out_valid_q    <= 1'b1;
        out_var_q      <= mem_q[rd_ptr_q];
        out_mask_q     <= 3'b000;
      end else begin
        out_msg_type_q <= MSG_NONE;
        out_valid_q    <= 1'b0;
      end

      // ARMED spans the downstream node's one-cycle delay in raising busy.
      // Without it, the stale dn_busy=0 would allow a second dispatch at once.
      case (state_q)
        ST_READY: if (dispatch) state_q <= ST_ARMED;
        ST_ARMED: state_q <= ST_WAIT;
        ST_WAIT:  if (!dn_busy) state_q <= ST_READY;
        default:  state_q <= ST_READY;
      endcase
    end
  end

  assign out_var      = out_var_q;
  assign out_valid    = out_valid_q;
  assign out_msg_type = out_msg_type_q;
  assign out_mask     = out_mask_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign dbg_state    = state_q;

endmodule
